// File: rtl/fpu_cvt_ctrl.sv
// Float-to-word conversion sequencer with its fpu_float2int datapath.
// Optional macro FPU_CVT_INEXACT_EN adds resp_inexact and the sticky flag_inexact.

module fpu_float2int (
  input  logic [31:0] operand,
  output logic [31:0] result_round,
  output logic [31:0] result_trunc,
  output logic [31:0] result_ceil,
  output logic [31:0] result_floor,
  output logic        invalid,
  output logic        inexact
);
  logic        sign;
  logic [7:0]  exp_raw;
  logic [7:0]  exp_eff;
  logic [23:0] mant;
  logic        big;
  logic [3:0]  lshift;
  logic [5:0]  rshift;
  logic [49:0] shifted;
  logic [31:0] mag_base;
  logic        round_bit;
  logic        sticky;
  logic        inc_round;
  logic        inc_ceil;
  logic        inc_floor;

  // Invalid operands always produce the positive saturation word.
  function automatic logic [31:0] to_word(input logic [31:0] mag, input logic inc,
                                          input logic neg, input logic bad);
    logic [31:0] m;
    m = mag + {31'b0, inc};
    if (bad) return 32'h7fffffff;
    return neg ? (~m + 32'd1) : m;
  endfunction

  always_comb begin
    sign    = operand[31];
    exp_raw = operand[30:23];
    exp_eff = (exp_raw == 8'd0) ? 8'd1 : exp_raw;
    mant    = {exp_raw != 8'd0, operand[22:0]};
    big     = exp_eff >= 8'd150;
    // exp - 150 only matters for 150..158, where the low nibble is exp[3:0] - 6.
    lshift  = exp_eff[3:0] - 4'd6;
    // Beyond 26 the integer part and round bit are zero; only the sticky bit remains.
    rshift  = (exp_eff < 8'd124) ? 6'd26 : 6'(8'd150 - exp_eff);
    shifted = {mant, 26'b0} >> rshift;
    if (big) begin
      mag_base  = {8'b0, mant} << lshift;
      round_bit = 1'b0;
      sticky    = 1'b0;
    end else begin
      mag_base  = {8'b0, shifted[49:26]};
      round_bit = shifted[25];
      sticky    = |shifted[24:0];
    end
    invalid   = (exp_raw > 8'd158) |
                ((exp_raw == 8'd158) & ~(sign & (operand[22:0] == 23'd0)));
    inexact   = (round_bit | sticky) & ~invalid;
    inc_round = round_bit & (sticky | mag_base[0]);
    inc_ceil  = ~sign & (round_bit | sticky);
    inc_floor = sign & (round_bit | sticky);
    result_round = to_word(mag_base, inc_round, sign, invalid);
    result_trunc = to_word(mag_base, 1'b0, sign, invalid);
    result_ceil  = to_word(mag_base, inc_ceil, sign, invalid);
    result_floor = to_word(mag_base, inc_floor, sign, invalid);
  end
endmodule

module fpu_cvt_ctrl #(
  parameter logic [31:0] RESET_RESULT = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_float,
  input  logic [1:0]  fcsr_rm,
  input  logic        fcsr_en_invalid,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_invalid,
  output logic        resp_trap,
  output logic        flag_invalid,
  input  logic        flag_clear,
`ifdef FPU_CVT_INEXACT_EN
  output logic        resp_inexact,
  output logic        flag_inexact,
`endif
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Handshakes: a transfer occurs on a rising edge where valid & ready are both 1;
  // req_ready never depends on req_valid and resp_valid never depends on resp_ready.
  state_t      state_q, state_d;
  logic        accept;
  logic        handshake;
  logic [1:0]  eff_op;
  logic [1:0]  op_q;
  logic [31:0] float_q;
  logic        en_q;
  logic [31:0] dp_round, dp_trunc, dp_ceil, dp_floor;
  logic        dp_invalid;
  logic        dp_inexact;
  logic [31:0] sel_word;

  assign req_ready  = ~flush & ((state_q == IDLE) | ((state_q == DONE) & resp_ready));
  assign accept     = req_valid & req_ready;
  assign handshake  = (state_q == DONE) & resp_ready & ~flush;
  assign resp_valid = (state_q == DONE);
  assign dbg_state  = state_q;

  // Effective op: 0=ROUND, 1=TRUNC, 2=CEIL, 3=FLOOR (same order as FCSR RM).
  always_comb begin
    eff_op = 2'd1;
    case (req_op)
      3'd0:    eff_op = fcsr_rm;
      3'd1:    eff_op = 2'd0;
      3'd2:    eff_op = 2'd1;
      3'd3:    eff_op = 2'd2;
      3'd4:    eff_op = 2'd3;
      default: eff_op = 2'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    state_d = DONE;
      DONE:    if (resp_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      float_q <= 32'h0;
      en_q    <= 1'b0;
      op_q    <= 2'd0;
    end else if (accept) begin
      float_q <= req_float;
      en_q    <= fcsr_en_invalid;
      op_q    <= eff_op;
    end
  end

  fpu_float2int u_float2int (
    .operand      (float_q),
    .result_round (dp_round),
    .result_trunc (dp_trunc),
    .result_ceil  (dp_ceil),
    .result_floor (dp_floor),
    .invalid      (dp_invalid),
    .inexact      (dp_inexact)
  );

  always_comb begin
    sel_word = dp_trunc;
    case (op_q)
      2'd0:    sel_word = dp_round;
      2'd1:    sel_word = dp_trunc;
      2'd2:    sel_word = dp_ceil;
      default: sel_word = dp_floor;
    endcase
  end

  // A flush keeps the last word/invalid visible but withdraws the trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_result  <= RESET_RESULT;
      resp_invalid <= 1'b0;
      resp_trap    <= 1'b0;
    end else if (flush) begin
      resp_trap    <= 1'b0;
    end else if (state_q == BUSY) begin
      resp_result  <= sel_word;
      resp_invalid <= dp_invalid;
      resp_trap    <= dp_invalid & en_q;
    end
  end

  // Set has priority over clear; a flushed handshake never sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_invalid <= 1'b0;
    else     flag_invalid <= (handshake & resp_invalid) | (flag_invalid & ~flag_clear);
  end

`ifdef FPU_CVT_INEXACT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               resp_inexact <= 1'b0;
    else if (!flush && (state_q == BUSY)) resp_inexact <= dp_inexact;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag_inexact <= 1'b0;
    else     flag_inexact <= (handshake & resp_inexact) | (flag_inexact & ~flag_clear);
  end
`else
  logic unused_inexact;
  assign unused_inexact = dp_inexact;
`endif
endmodule

// File: tb/tb_fpu_cvt_ctrl.sv
// Directed bench for fpu_cvt_ctrl: driver tasks, expected-queue scoreboard, summary.
module tb_fpu_cvt_ctrl;
  localparam logic [31:0] RESET_RESULT = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_float;
  logic [1:0]  fcsr_rm;
  logic        fcsr_en_invalid;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_invalid;
  logic        resp_trap;
  logic        flag_invalid;
  logic        flag_clear;
  logic [1:0]  dbg_state;
`ifdef FPU_CVT_INEXACT_EN
  logic        resp_inexact;
  logic        flag_inexact;
`endif

  fpu_cvt_ctrl #(.RESET_RESULT(RESET_RESULT)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_float       (req_float),
    .fcsr_rm         (fcsr_rm),
    .fcsr_en_invalid (fcsr_en_invalid),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_result     (resp_result),
    .resp_invalid    (resp_invalid),
    .resp_trap       (resp_trap),
    .flag_invalid    (flag_invalid),
    .flag_clear      (flag_clear),
`ifdef FPU_CVT_INEXACT_EN
    .resp_inexact    (resp_inexact),
    .flag_inexact    (flag_inexact),
`endif
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected response: {result[31:0], invalid, trap, inexact}
  logic [34:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops on every completed (unflushed) response handshake.
  always @(negedge clk) begin : monitor
    logic [34:0] e;
    if (!rst && resp_valid && resp_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h expected no response", resp_result);
      end else begin
        e = exp_q.pop_front();
        check("resp_result", resp_result, e[34:3]);
        check_bit("resp_invalid", resp_invalid, e[2]);
        check_bit("resp_trap", resp_trap, e[1]);
`ifdef FPU_CVT_INEXACT_EN
        check_bit("resp_inexact", resp_inexact, e[0]);
`endif
      end
    end
  end

  // Driver: present a request, return at posedge+1 after the accept edge.
  task automatic send(input logic [2:0] op, input logic [31:0] f, input logic [1:0] rm,
                      input logic en, input logic push, input logic [31:0] w,
                      input logic inv, input logic inx);
    int  budget;
    logic done;
    req_op          = op;
    req_float       = f;
    fcsr_rm         = rm;
    fcsr_en_invalid = en;
    req_valid       = 1'b1;
    if (push) exp_q.push_back({w, inv, inv & en, inx});
    budget = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      else if (budget > 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles");
        done = 1'b1;
      end
      budget++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic check_latency();
    @(negedge clk);
    check_bit("lat_busy_valid", resp_valid, 1'b0);
    @(negedge clk);
    check_bit("lat_done_valid", resp_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    flag_clear = 1'b1;
    @(posedge clk);
    #1;
    flag_clear = 1'b0;
  endtask

  // Directed table: op, operand, expected word, expected inexact
  logic [2:0]  t_op[10]  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd4, 3'd2, 3'd6, 3'd2};
  logic [31:0] t_f[10]   = '{32'h00000000, 32'hC0200000, 32'h40200000, 32'h3F000000,
                             32'h3F000000, 32'hBE800000, 32'hBE800000, 32'hCF000000,
                             32'h3FC00000, 32'h40000000};
  logic [31:0] t_w[10]   = '{32'h00000000, 32'hFFFFFFFE, 32'h00000002, 32'h00000000,
                             32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h80000000,
                             32'h00000001, 32'h00000002};
  logic        t_inx[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [2:0]  t1_op[4]  = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] t1_w[4]   = '{32'd2, 32'd1, 32'd2, 32'd1};

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_float = 32'h0;
    fcsr_rm = 2'd0; fcsr_en_invalid = 1'b0; resp_ready = 1'b1; flag_clear = 1'b0;
    #12;
    check_bit("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_result", resp_result, RESET_RESULT);
    check_bit("rst_resp_invalid", resp_invalid, 1'b0);
    check_bit("rst_resp_trap", resp_trap, 1'b0);
    check_bit("rst_flag_invalid", flag_invalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1.5 under the four explicit rounding ops
    for (int i = 0; i < 4; i++) begin
      send(t1_op[i], 32'h3FC00000, 2'd0, 1'b0, 1'b1, t1_w[i], 1'b0, 1'b1);
      check_latency();
    end

    // -1.5 CEIL/FLOOR, then CVT through fcsr_rm with rm toggled during BUSY
    send(3'd3, 32'hBFC00000, 2'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    check_latency();
    send(3'd4, 32'hBFC00000, 2'd0, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1);
    check_latency();
    send(3'd0, 32'h3FC00000, 2'd2, 1'b0, 1'b1, 32'd2, 1'b0, 1'b1);
    fcsr_rm = 2'd1;
    check_latency();
    send(3'd0, 32'h3FC00000, 2'd1, 1'b0, 1'b1, 32'd1, 1'b0, 1'b1);
    fcsr_rm = 2'd2;
    check_latency();

    // Ties, zero, small magnitudes, INT_MIN, reserved op, exact value
    for (int i = 0; i < 10; i++) begin
      send(t_op[i], t_f[i], 2'd0, 1'b1, 1'b1, t_w[i], 1'b0, t_inx[i]);
      check_latency();
    end
    check_bit("flag_invalid_valid_ops", flag_invalid, 1'b0);

    // Out-of-range with trap enabled, NaN and +2^31 without
    send(3'd2, 32'h4F32D05E, 2'd0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    check_latency();
    check_bit("flag_invalid_set", flag_invalid, 1'b1);
    pulse_clear();
    check_bit("flag_invalid_cleared", flag_invalid, 1'b0);
`ifdef FPU_CVT_INEXACT_EN
    check_bit("flag_inexact_cleared", flag_inexact, 1'b0);
`endif
    send(3'd2, 32'h7FC00000, 2'd0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    check_latency();
    check_bit("flag_invalid_nan", flag_invalid, 1'b1);
    send(3'd2, 32'h4F000000, 2'd0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    check_latency();
    pulse_clear();
    check_bit("flag_invalid_cleared2", flag_invalid, 1'b0);

    // Backpressure in DONE, then back-to-back accept
    resp_ready = 1'b0;
    send(3'd1, 32'h3FC00000, 2'd0, 1'b0, 1'b1, 32'd2, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("hold_valid", resp_valid, 1'b1);
      check("hold_result", resp_result, 32'd2);
      check_bit("hold_req_ready", req_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    send(3'd4, 32'hBFC00000, 2'd0, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1);
    check_latency();

    // Flush in BUSY with a competing request
    send(3'd2, 32'h4F32D05E, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    flush = 1'b1;
    req_valid = 1'b1;
    req_op = 3'd1;
    req_float = 32'h3FC00000;
    @(negedge clk);
    check_bit("flush_busy_req_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_bit("flush_busy_valid", resp_valid, 1'b0);
    end
    check_bit("flush_busy_flag", flag_invalid, 1'b0);
    @(posedge clk);
    #1;

    // Flush in DONE coinciding with a ready consumer
    send(3'd2, 32'h4F32D05E, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check_bit("flush_done_req_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_bit("flush_done_valid", resp_valid, 1'b0);
    check_bit("flush_done_flag", flag_invalid, 1'b0);
    check_bit("flush_done_trap", resp_trap, 1'b0);
    check("flush_done_result_kept", resp_result, 32'h7FFFFFFF);
    check_bit("flush_done_invalid_kept", resp_invalid, 1'b1);
    @(posedge clk);
    #1;

    // Clear coinciding with an invalid handshake: set wins
    send(3'd2, 32'h4F32D05E, 2'd0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    pulse_clear();
    check_bit("set_beats_clear", flag_invalid, 1'b1);

    // Asynchronous reset mid-BUSY
    send(3'd1, 32'h3FC00000, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_bit("arst_valid", resp_valid, 1'b0);
    check("arst_result", resp_result, RESET_RESULT);
    check_bit("arst_invalid", resp_invalid, 1'b0);
    check_bit("arst_trap", resp_trap, 1'b0);
    check_bit("arst_flag", flag_invalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_bit("arst_no_resp", resp_valid, 1'b0);
    @(posedge clk);
    #1;

    // Inexact vs exact conversion
    send(3'd2, 32'h3FC00000, 2'd0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b1);
    check_latency();
`ifdef FPU_CVT_INEXACT_EN
    check_bit("flag_inexact_set", flag_inexact, 1'b1);
`endif
    send(3'd2, 32'h40000000, 2'd0, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0);
    check_latency();

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_cvt_ctrl.md
Name: fpu_cvt_ctrl

Overview:
Sequencer for the single-precision float-to-word conversion datapath (one fpu_float2int instance) inside the FPU.
- Accepts one conversion request at a time from EX: CVT.W.S, ROUND.W.S, TRUNC.W.S, CEIL.W.S, FLOOR.W.S.
- Resolves the rounding mode and registers the operand.
- Selects the matching datapath output and registers the result.
- Holds the result under a valid/ready handshake.
- Maintains the sticky FCSR invalid flag and raises a trap indication.

Parameters:
RESET_RESULT, 32'h0, value driven on resp_result while reset is asserted

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  pipeline flush; drops any in-flight op
req_valid  in  1  request present
req_ready  out  1  controller can accept this cycle
req_op  in  3  0=CVT(use rm), 1=ROUND, 2=TRUNC, 3=CEIL, 4=FLOOR, 5-7 reserved (treated as TRUNC)
req_float  in  32  IEEE-754 single operand
fcsr_rm  in  2  FCSR RM: 0=nearest, 1=zero, 2=+inf, 3=-inf
fcsr_en_invalid  in  1  FCSR invalid-operation enable bit
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_result  out  32  converted word
resp_invalid  out  1  conversion invalid (out of range, Inf, NaN)
resp_trap  out  1  resp_invalid & enable sampled at accept
flag_invalid  out  1  sticky FCSR invalid flag
flag_clear  in  1  clears flag_invalid (FCSR write)

Behaviour:
- States: IDLE, BUSY, DONE. Encoding is free.
- Reset (async, rst=1): state=IDLE, resp_valid=0, resp_result=RESET_RESULT, resp_invalid=0, resp_trap=0, flag_invalid=0.
- req_ready = (state==IDLE) | (state==DONE & resp_ready), and is forced to 0 when flush=1.
- Accept = req_valid & req_ready.
  - On accept: latch req_float, latch the enable bit, latch the effective op.
  - CVT resolves at accept via fcsr_rm: 0→ROUND, 1→TRUNC, 2→CEIL, 3→FLOOR.
  - A later change to fcsr_rm does not affect an accepted op.
- IDLE → BUSY on accept.
- BUSY → DONE unconditionally next cycle.
  - The datapath sees the latched operand.
  - The selected word and invalid bit are registered into resp_result/resp_invalid.
  - resp_trap is registered as invalid & the latched enable.
- DONE: resp_valid=1. Outputs are held stable until the handshake.
  - resp_ready=1 without accept → IDLE.
  - resp_ready=1 with accept → BUSY (back-to-back).
- Latency: accepted in cycle N → resp_valid=1 in cycle N+2. Throughput is one op per 2 cycles.
- Invalid results are the saturated value from the datapath (32'h7fffffff for NaN/Inf/overflow). The controller does not modify the word.
- flag_invalid:
  - Set on the cycle the response handshake (DONE & resp_ready) completes with resp_invalid=1.
  - flag_clear=1 clears it.
  - If set and clear coincide, set wins.
- flush=1 in any state → IDLE next edge.
  - resp_valid drops next cycle.
  - An accept in the same cycle is blocked.
  - A response handshake coinciding with flush is discarded and does not set flag_invalid.
  - resp_result/resp_invalid keep their last values; resp_trap clears.
- rst mid-operation: immediate return to reset values, with no flag update.
- No combinational path from req_* to resp_*.

Optional Feature:
FPU_CVT_INEXACT_EN
- Defined:
  - Adds output ports resp_inexact (1) and flag_inexact (1).
  - resp_inexact=1 when the operand magnitude is not an integer and the result is not invalid. For a finite nonzero operand this means exponent<150 with nonzero fraction bits below the binary point; every value with exponent<127 and nonzero magnitude counts.
  - resp_inexact is registered alongside resp_result.
  - flag_inexact is sticky with the same set/clear/flush rules as flag_invalid and is cleared by flag_clear.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. 1.5 (0x3FC00000), ops ROUND/TRUNC/CEIL/FLOOR → 2, 1, 2, 1; resp_invalid=0; resp_valid exactly 2 cycles after each accept.
2. -1.5 (0xBFC00000), CEIL → 0xFFFFFFFF, FLOOR → 0xFFFFFFFE; CVT with rm=2 on 1.5 → 2, then CVT with rm=1 on 1.5 → 1; fcsr_rm toggled during BUSY does not change the result.
3. 3.0e9 (0x4F32D05E) TRUNC with en_invalid=1 → 0x7FFFFFFF, resp_invalid=1, resp_trap=1, flag_invalid=1 after handshake; NaN 0x7FC00000 with en=0 → 0x7FFFFFFF, invalid=1, trap=0.
4. Hold resp_ready=0 for 5 cycles in DONE → outputs stable, req_ready=0; then resp_ready=1 with req_valid=1 → back-to-back accept, next result 2 cycles later.
5. flush asserted in BUSY and again in DONE with resp_ready=1 on an invalid op → IDLE next cycle, resp_valid=0, flag_invalid unchanged; flag_clear coinciding with an invalid handshake → flag_invalid stays 1.
6. rst pulsed asynchronously mid-BUSY → all outputs at reset values immediately; with FPU_CVT_INEXACT_EN, 1.5 TRUNC → resp_inexact=1 and 2.0 (0x40000000) → resp_inexact=0.
